// File: rtl/invaders_game_logic_if.sv
// Frame-tick, button and sprite-grid bundle between the game engine
// and its timing/input source and renderer.
interface invaders_game_logic_if;
  logic        i_frame_tick;
  logic        i_left;
  logic        i_right;
  logic        i_fire;
  logic [19:0] o_invaders_array;
  logic [3:0]  o_invaders_line;
  logic [4:0]  o_ship_x;
  logic [4:0]  o_bullet_x;
  logic [3:0]  o_bullet_y;
  logic [1:0]  o_gameplay;

  modport master (
    output i_frame_tick, i_left, i_right, i_fire,
    input  o_invaders_array, o_invaders_line,
    input  o_ship_x, o_bullet_x, o_bullet_y, o_gameplay
  );

  modport slave (
    input  i_frame_tick, i_left, i_right, i_fire,
    output o_invaders_array, o_invaders_line,
    output o_ship_x, o_bullet_x, o_bullet_y, o_gameplay
  );
endinterface

// File: rtl/invaders_game_logic.sv
// Space Invaders game-state engine, one update per frame tick.
// Define AUTO_RESTART_EN to let fire restart a finished game.
module invaders_game_logic #(
  parameter int INVADER_PERIOD = 30,
  parameter int BULLET_PERIOD  = 4,
  parameter int SHIP_PERIOD    = 6
) (
  input logic i_clk,
  input logic i_reset,
  invaders_game_logic_if.slave bus
);

  typedef enum logic [1:0] {
    PLAYING   = 2'b00,
    YOU_WIN   = 2'b01,
    GAME_OVER = 2'b10
  } gp_t;

  localparam int IW = $clog2(INVADER_PERIOD + 1);
  localparam int BW = $clog2(BULLET_PERIOD + 1);
  localparam int SW = $clog2(SHIP_PERIOD + 1);
  localparam logic [IW-1:0] ILAST = IW'(INVADER_PERIOD - 1);
  localparam logic [BW-1:0] BLAST = BW'(BULLET_PERIOD - 1);
  localparam logic [SW-1:0] SLAST = SW'(SHIP_PERIOD - 1);

  logic [19:0]   arr, n_arr;
  logic [3:0]    line, n_line;
  logic          dir, n_dir;
  logic [4:0]    ship, n_ship;
  logic [4:0]    bx, n_bx;
  logic [3:0]    by, n_by;
  gp_t           state, n_state;
  logic [IW-1:0] icnt, n_icnt;
  logic [BW-1:0] bcnt, n_bcnt;
  logic [SW-1:0] scnt, n_scnt;

  logic upd;
  logic restart;
  logic i_ev, b_ev, s_ev;

  assign upd  = bus.i_frame_tick && (state == PLAYING);
  assign i_ev = (icnt == ILAST);
  assign b_ev = (bcnt == BLAST);
  assign s_ev = (scnt == SLAST);

`ifdef AUTO_RESTART_EN
  assign restart = bus.i_frame_tick && bus.i_fire
                && (state != PLAYING);
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    n_arr   = arr;
    n_line  = line;
    n_dir   = dir;
    n_ship  = ship;
    n_bx    = bx;
    n_by    = by;
    n_state = state;
    n_icnt  = i_ev ? '0 : icnt + 1'b1;
    n_bcnt  = b_ev ? '0 : bcnt + 1'b1;
    n_scnt  = s_ev ? '0 : scnt + 1'b1;

    // Launch and advance are exclusive: idle bullets only launch.
    if (by == 4'd15) begin
      if (b_ev && bus.i_fire) begin
        n_bx = ship;
        n_by = 4'd12;
      end
    end else if (b_ev) begin
      if (by == line && arr[bx]) begin
        n_arr[bx] = 1'b0;
        n_by      = 4'd15;
      end else if (by == 4'd0) begin
        n_by = 4'd15;
      end else begin
        n_by = by - 4'd1;
      end
    end

    if (i_ev && n_arr != '0) begin
      if (dir && n_arr[19]) begin
        n_line = line + 4'd1;
        n_dir  = 1'b0;
      end else if (!dir && n_arr[0]) begin
        n_line = line + 4'd1;
        n_dir  = 1'b1;
      end else if (dir) begin
        n_arr = n_arr << 1;
      end else begin
        n_arr = n_arr >> 1;
      end
    end

    if (s_ev) begin
      case ({bus.i_left, bus.i_right})
        2'b10:   n_ship = (ship == 5'd0) ? ship : ship - 5'd1;
        2'b01:   n_ship = (ship == 5'd19) ? ship : ship + 5'd1;
        default: n_ship = ship;
      endcase
    end

    if (n_arr == '0)
      n_state = YOU_WIN;
    else if (n_line >= 4'd13)
      n_state = GAME_OVER;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset || restart) begin
      arr   <= 20'h07FE0;
      line  <= 4'd1;
      dir   <= 1'b1;
      ship  <= 5'd9;
      bx    <= 5'd0;
      by    <= 4'd15;
      state <= PLAYING;
      icnt  <= '0;
      bcnt  <= '0;
      scnt  <= '0;
    end else if (upd) begin
      arr   <= n_arr;
      line  <= n_line;
      dir   <= n_dir;
      ship  <= n_ship;
      bx    <= n_bx;
      by    <= n_by;
      state <= n_state;
      icnt  <= n_icnt;
      bcnt  <= n_bcnt;
      scnt  <= n_scnt;
    end
  end

  assign bus.o_invaders_array = arr;
  assign bus.o_invaders_line  = line;
  assign bus.o_ship_x         = ship;
  assign bus.o_bullet_x       = bx;
  assign bus.o_bullet_y       = by;
  assign bus.o_gameplay       = state;

endmodule

// File: tb/tb_invaders_game_logic.sv
// Directed bench: three engines with different period settings
// exercise marching, ship, bullet hits, win/lose and reset priority.
module tb_invaders_game_logic;

  logic clk = 1'b0;
  logic rst_ab;
  logic rst_c;
  int   checks = 0;
  int   errors = 0;
  int   pos;
  logic [19:0] exp_b;

  always #5 clk = ~clk;

  invaders_game_logic_if ia ();
  invaders_game_logic_if ib ();
  invaders_game_logic_if ic ();

  invaders_game_logic #(
    .INVADER_PERIOD(1), .BULLET_PERIOD(1), .SHIP_PERIOD(1)
  ) dut_a (.i_clk(clk), .i_reset(rst_ab), .bus(ia));

  invaders_game_logic #(
    .INVADER_PERIOD(1000), .BULLET_PERIOD(1), .SHIP_PERIOD(1)
  ) dut_b (.i_clk(clk), .i_reset(rst_ab), .bus(ib));

  invaders_game_logic dut_c (.i_clk(clk), .i_reset(rst_c), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // m selects which engines see the frame tick: bit0 A, bit1 B, bit2 C
  task automatic ticks(input int n, input logic [2:0] m);
    for (int i = 0; i < n; i++) begin
      ia.i_frame_tick = m[0];
      ib.i_frame_tick = m[1];
      ic.i_frame_tick = m[2];
      @(posedge clk);
      #1;
      ia.i_frame_tick = 1'b0;
      ib.i_frame_tick = 1'b0;
      ic.i_frame_tick = 1'b0;
    end
  endtask

  task automatic kill(input int c);
    while (pos != c) begin
      if (pos < c) begin
        ib.i_right = 1'b1;
        pos++;
      end else begin
        ib.i_left = 1'b1;
        pos--;
      end
      ticks(1, 3'b010);
      ib.i_left  = 1'b0;
      ib.i_right = 1'b0;
    end
    ib.i_fire = 1'b1;
    ticks(1, 3'b010);
    ib.i_fire = 1'b0;
    chk("b_launch_x", ib.o_bullet_x, c);
    ticks(12, 3'b010);
    exp_b[c] = 1'b0;
    chk("b_kill_arr", ib.o_invaders_array, exp_b);
    chk("b_kill_by", ib.o_bullet_y, 15);
  endtask

  initial begin
    {ia.i_frame_tick, ia.i_left, ia.i_right, ia.i_fire} = '0;
    {ib.i_frame_tick, ib.i_left, ib.i_right, ib.i_fire} = '0;
    {ic.i_frame_tick, ic.i_left, ic.i_right, ic.i_fire} = '0;
    rst_ab = 1'b0;
    rst_c  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ab = 1'b1;
    rst_c  = 1'b1;

    chk("rst_arr", ia.o_invaders_array, 20'h07FE0);
    chk("rst_line", ia.o_invaders_line, 1);
    chk("rst_ship", ia.o_ship_x, 9);
    chk("rst_bx", ia.o_bullet_x, 0);
    chk("rst_by", ia.o_bullet_y, 15);
    chk("rst_gp", ia.o_gameplay, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_arr", ia.o_invaders_array, 20'h07FE0);
    chk("idle_ship", ia.o_ship_x, 9);

    // A: march, turn at the right edge, ship movement
    ticks(5, 3'b001);
    chk("a5_arr", ia.o_invaders_array, 20'hFFC00);
    chk("a5_line", ia.o_invaders_line, 1);
    ticks(1, 3'b001);
    chk("a6_arr", ia.o_invaders_array, 20'hFFC00);
    chk("a6_line", ia.o_invaders_line, 2);
    ticks(1, 3'b001);
    chk("a7_arr", ia.o_invaders_array, 20'h7FE00);
    ia.i_right = 1'b1;
    ticks(15, 3'b001);
    chk("a_ship_sat", ia.o_ship_x, 19);
    ia.i_left = 1'b1;
    ticks(3, 3'b001);
    chk("a_ship_both", ia.o_ship_x, 19);
    ia.i_right = 1'b0;
    ticks(2, 3'b001);
    ia.i_left = 1'b0;
    chk("a_ship_left", ia.o_ship_x, 17);
    chk("a27_arr", ia.o_invaders_array, 20'hFFC00);
    chk("a27_line", ia.o_invaders_line, 3);
    ticks(99, 3'b001);
    chk("a126_arr", ia.o_invaders_array, 20'h003FF);
    chk("a126_line", ia.o_invaders_line, 12);
    chk("a126_gp", ia.o_gameplay, 0);
    ticks(1, 3'b001);
    chk("a_over_line", ia.o_invaders_line, 13);
    chk("a_over_arr", ia.o_invaders_array, 20'h003FF);
    chk("a_over_gp", ia.o_gameplay, 2);
    ia.i_right = 1'b1;
    ticks(3, 3'b001);
    ia.i_right = 1'b0;
    chk("a_frz_ship", ia.o_ship_x, 17);
    chk("a_frz_line", ia.o_invaders_line, 13);
    chk("a_frz_gp", ia.o_gameplay, 2);
    ia.i_fire = 1'b1;
    ticks(1, 3'b001);
    ia.i_fire = 1'b0;
`ifdef AUTO_RESTART_EN
    chk("a_rs_arr", ia.o_invaders_array, 20'h07FE0);
    chk("a_rs_line", ia.o_invaders_line, 1);
    chk("a_rs_ship", ia.o_ship_x, 9);
    chk("a_rs_by", ia.o_bullet_y, 15);
    chk("a_rs_gp", ia.o_gameplay, 0);
`else
    chk("a_fire_gp", ia.o_gameplay, 2);
    chk("a_fire_by", ia.o_bullet_y, 15);
    chk("a_fire_arr", ia.o_invaders_array, 20'h003FF);
`endif

    // B: bullet flight and hit, then clear the whole band
    ib.i_fire = 1'b1;
    ticks(1, 3'b010);
    ib.i_fire = 1'b0;
    chk("b_launch_x", ib.o_bullet_x, 9);
    chk("b_launch_y", ib.o_bullet_y, 12);
    ticks(11, 3'b010);
    chk("b_row1_y", ib.o_bullet_y, 1);
    chk("b_row1_x", ib.o_bullet_x, 9);
    ticks(1, 3'b010);
    chk("b_hit_arr", ib.o_invaders_array, 20'h07DE0);
    chk("b_hit_by", ib.o_bullet_y, 15);
    exp_b = 20'h07DE0;
    pos = 9;
    kill(10);
    kill(11);
    kill(12);
    kill(13);
    kill(14);
    kill(8);
    kill(7);
    kill(6);
    kill(5);
    chk("b_win_gp", ib.o_gameplay, 1);
    ib.i_right = 1'b1;
    ticks(3, 3'b010);
    ib.i_right = 1'b0;
    chk("b_frz_ship", ib.o_ship_x, 5);
    chk("b_frz_gp", ib.o_gameplay, 1);
    chk("b_frz_arr", ib.o_invaders_array, 0);

    // C: default periods, then reset wins over a same-cycle tick
    ic.i_fire = 1'b1;
    ticks(29, 3'b100);
    chk("c29_arr", ic.o_invaders_array, 20'h07FE0);
    chk("c29_by", ic.o_bullet_y, 6);
    chk("c29_bx", ic.o_bullet_x, 9);
    ticks(1, 3'b100);
    chk("c30_arr", ic.o_invaders_array, 20'h0FFC0);
    chk("c30_by", ic.o_bullet_y, 6);
    rst_c = 1'b0;
    ticks(1, 3'b100);
    rst_c = 1'b1;
    ic.i_fire = 1'b0;
    chk("c_rst_arr", ic.o_invaders_array, 20'h07FE0);
    chk("c_rst_by", ic.o_bullet_y, 15);
    chk("c_rst_bx", ic.o_bullet_x, 0);
    chk("c_rst_ship", ic.o_ship_x, 9);
    chk("c_rst_gp", ic.o_gameplay, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
